// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - round-robin sharing of the genrom read port between two requesters
module rom_port_arbiter #(
  parameter int MEM_ADDR    = 6,
  parameter int MEM_EXTRA   = 4,
  parameter int ROM_LATENCY = 1,
  localparam int AW = MEM_ADDR + 1,
  localparam int DW = (1 << MEM_EXTRA) * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [MEM_EXTRA-1:0] extra0,
  input  logic [MEM_EXTRA-1:0] extra1,
  input  logic [AW-1:0]        lower0,
  input  logic [AW-1:0]        upper0,
  input  logic [AW-1:0]        lower1,
  input  logic [AW-1:0]        upper1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DW-1:0]        rdata,
  output logic                 rerror,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  output logic [AW-1:0]        rom_lower_bound,
  output logic [AW-1:0]        rom_upper_bound,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error
);

  localparam int CW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          owner;
  logic          grant_any;
  logic          grant_port;
  logic          ack0_nx;
  logic          ack1_nx;
  logic          rvalid0_nx;
  logic          rvalid1_nx;
  logic          busy_nx;

  // Arbitration is only open in IDLE and RESP; a tie goes to the port that did not win last
  always_comb begin
    grant_any  = ((state == S_IDLE) || (state == S_RESP)) && (req0 || req1);
    grant_port = (req0 && req1) ? ~last_grant : req1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: WAIT lasts ROM_LATENCY cycles, then one capture cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RESP: state_nx = grant_any ? S_WAIT : S_IDLE;
      S_WAIT:         state_nx = (cnt == '0) ? S_CAPT : S_WAIT;
      S_CAPT:         state_nx = S_RESP;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Next values of the pulse/status outputs, registered below
  always_comb begin
    ack0_nx    = grant_any && !grant_port;
    ack1_nx    = grant_any &&  grant_port;
    rvalid0_nx = (state == S_CAPT) && !owner;
    rvalid1_nx = (state == S_CAPT) &&  owner;
    busy_nx    = (state_nx == S_WAIT) || (state_nx == S_CAPT);
  end

  // Registered outputs, captured request fields, latency counter and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rvalid0         <= 1'b0;
      rvalid1         <= 1'b0;
      busy            <= 1'b0;
      rdata           <= '0;
      rerror          <= 1'b0;
      mem_addr        <= '0;
      mem_extra       <= '0;
      rom_lower_bound <= '0;
      rom_upper_bound <= '1;
      cnt             <= '0;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
    end else begin
      ack0    <= ack0_nx;
      ack1    <= ack1_nx;
      rvalid0 <= rvalid0_nx;
      rvalid1 <= rvalid1_nx;
      busy    <= busy_nx;
      if (grant_any) begin
        mem_addr        <= grant_port ? addr1  : addr0;
        mem_extra       <= grant_port ? extra1 : extra0;
        rom_lower_bound <= grant_port ? lower1 : lower0;
        rom_upper_bound <= grant_port ? upper1 : upper0;
        owner           <= grant_port;
        last_grant      <= grant_port;
        cnt             <= CW'(ROM_LATENCY - 1);
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (state == S_CAPT) begin
        rdata  <= mem_data;
        rerror <= mem_error;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - randomized and directed self-checking bench for rom_port_arbiter
module tb_rom_port_arbiter;

  localparam int AW = 7;
  localparam int XW = 4;
  localparam int DW = 128;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [128];
  int passed = 0;
  int total = 0;

  // Instance with the default latency
  logic req0 = 0, req1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, lower0 = '0, upper0 = '1, lower1 = '0, upper1 = '1;
  logic [XW-1:0] extra0 = '0, extra1 = '0;
  logic ack0, ack1, rvalid0, rvalid1, rerror, busy, mem_error;
  logic [DW-1:0] rdata, mem_data;
  logic [AW-1:0] mem_addr, rom_lower_bound, rom_upper_bound;
  logic [XW-1:0] mem_extra;

  // Instance with a three-cycle ROM
  logic req0_3 = 0, req1_3 = 0;
  logic [AW-1:0] addr0_3 = '0, addr1_3 = '0, lower1_3 = '0, upper1_3 = '1;
  logic [XW-1:0] extra1_3 = '0;
  logic ack0_3, ack1_3, rvalid0_3, rvalid1_3, rerror_3, busy_3, mem_error_3;
  logic [DW-1:0] rdata_3, mem_data_3;
  logic [AW-1:0] mem_addr_3, rom_lower_bound_3, rom_upper_bound_3;
  logic [XW-1:0] mem_extra_3;

  rom_port_arbiter u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .extra0(extra0), .extra1(extra1),
    .lower0(lower0), .upper0(upper0), .lower1(lower1), .upper1(upper1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rerror(rerror), .busy(busy),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .rom_lower_bound(rom_lower_bound), .rom_upper_bound(rom_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  rom_port_arbiter #(.ROM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req0(req0_3), .req1(req1_3),
    .addr0(addr0_3), .addr1(addr1_3), .extra0(4'd0), .extra1(extra1_3),
    .lower0(7'd0), .upper0(7'd127), .lower1(lower1_3), .upper1(upper1_3),
    .ack0(ack0_3), .ack1(ack1_3), .rvalid0(rvalid0_3), .rvalid1(rvalid1_3),
    .rdata(rdata_3), .rerror(rerror_3), .busy(busy_3),
    .mem_addr(mem_addr_3), .mem_extra(mem_extra_3),
    .rom_lower_bound(rom_lower_bound_3), .rom_upper_bound(rom_upper_bound_3),
    .mem_data(mem_data_3), .mem_error(mem_error_3)
  );

  // Behavioural ROM: little-endian bytes addr..addr+extra, zero above; error when outside the window
  function automatic logic [DW-1:0] rom_read(input logic [AW-1:0] a, input logic [XW-1:0] x);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i <= int'(x); i++) d[i*8 +: 8] = rom[(int'(a) + i) % 128];
    return d;
  endfunction

  function automatic logic rom_err(input logic [AW-1:0] a, input logic [XW-1:0] x,
                                   input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    return (a < lo) || (int'(a) + int'(x) > int'(hi));
  endfunction

  always_comb begin
    mem_data    = rom_read(mem_addr, mem_extra);
    mem_error   = rom_err(mem_addr, mem_extra, rom_lower_bound, rom_upper_bound);
    mem_data_3  = rom_read(mem_addr_3, mem_extra_3);
    mem_error_3 = rom_err(mem_addr_3, mem_extra_3, rom_lower_bound_3, rom_upper_bound_3);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; req0_3 = 0; req1_3 = 0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    total++; if ({ack0, ack1, rvalid0, rvalid1, busy, rerror} !== 6'b0) $display("FAIL reset_flags got %b exp 000000", {ack0, ack1, rvalid0, rvalid1, busy, rerror}); else passed++;
    total++; if (rdata !== '0) $display("FAIL reset_rdata got %h exp 0", rdata); else passed++;
    total++; if ({mem_addr, mem_extra} !== 11'd0) $display("FAIL reset_mem got %h exp 0", {mem_addr, mem_extra}); else passed++;
    total++; if ({rom_lower_bound, rom_upper_bound} !== {7'd0, 7'h7f}) $display("FAIL reset_bounds got %h/%h exp 00/7f", rom_lower_bound, rom_upper_bound); else passed++;
    do_reset();
  endtask

  task automatic test_single();
    req0 = 1; addr0 = 7'd33; extra0 = 4'd1; lower0 = 7'd0; upper0 = 7'd127;
    step();
    total++; if ({ack0, ack1} !== 2'b10) $display("FAIL single_ack_c1 got %b exp 10", {ack0, ack1}); else passed++;
    total++; if (mem_addr !== 7'd33) $display("FAIL single_addr_c1 got %0d exp 33", mem_addr); else passed++;
    req0 = 0; addr0 = 7'd99;
    step();
    total++; if ({ack0, busy, mem_addr} !== {1'b0, 1'b1, 7'd33}) $display("FAIL single_c2 got %b/%b/%0d exp 0/1/33", ack0, busy, mem_addr); else passed++;
    step();
    total++; if ({rvalid0, rvalid1} !== 2'b10) $display("FAIL single_rvalid_c3 got %b exp 10", {rvalid0, rvalid1}); else passed++;
    total++; if ({rdata[15:0], rerror} !== {16'h0320, 1'b0}) $display("FAIL single_data got %h/%b exp 0320/0", rdata[15:0], rerror); else passed++;
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; addr0 = 7'd33; extra0 = 4'd1;
    step();
    req0 = 0;
    step();
    reset = 1'b0;
    #1;
    total++; if ({busy, rvalid0} !== 2'b00) $display("FAIL midreset_busy got %b exp 00", {busy, rvalid0}); else passed++;
    total++; if (rdata !== '0) $display("FAIL midreset_rdata got %h exp 0", rdata); else passed++;
    total++; if (mem_addr !== 7'd0) $display("FAIL midreset_addr got %0d exp 0", mem_addr); else passed++;
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if ({rvalid0, busy} !== 2'b00) $display("FAIL midreset_after_c%0d got %b exp 00", c, {rvalid0, busy}); else passed++;
    end
    req0 = 1; req1 = 1;
    step();
    total++; if ({ack0, ack1} !== 2'b10) $display("FAIL midreset_firstgrant got %b exp 10", {ack0, ack1}); else passed++;
    req0 = 0; req1 = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if ({ack1, rvalid1} !== 2'b00) $display("FAIL dropped_req1_c%0d got %b exp 00", c, {ack1, rvalid1}); else passed++;
    end
  endtask

  task automatic test_tie();
    logic [3:0] e;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 7'd0; addr1 = 7'd10; extra0 = 0; extra1 = 0;
    lower0 = 0; upper0 = 127; lower1 = 0; upper1 = 127;
    for (int c = 1; c <= 12; c++) begin
      step();
      e = {c % 6 == 1, c % 6 == 4, c % 6 == 3, c % 6 == 0};
      total++; if ({ack0, ack1, rvalid0, rvalid1} !== e) $display("FAIL tie_c%0d got %b exp %b", c, {ack0, ack1, rvalid0, rvalid1}, e); else passed++;
    end
    req0 = 0; req1 = 0;
    repeat (3) step();
  endtask

  task automatic test_bounds();
    do_reset();
    req1 = 1; addr1 = 7'd20; extra1 = 0; lower1 = 7'd40; upper1 = 7'd63;
    step();
    req1 = 0;
    total++; if ({ack1, rom_lower_bound, rom_upper_bound} !== {1'b1, 7'd40, 7'd63}) $display("FAIL bounds_c1 got %b/%0d/%0d exp 1/40/63", ack1, rom_lower_bound, rom_upper_bound); else passed++;
    step();
    total++; if ({rom_lower_bound, rom_upper_bound} !== {7'd40, 7'd63}) $display("FAIL bounds_c2 got %0d/%0d exp 40/63", rom_lower_bound, rom_upper_bound); else passed++;
    step();
    total++; if ({rvalid1, rerror} !== 2'b11) $display("FAIL bounds_err got %b exp 11", {rvalid1, rerror}); else passed++;
    req0 = 1; addr0 = 7'd20; extra0 = 0; lower0 = 0; upper0 = 127;
    step();
    req0 = 0;
    total++; if (ack0 !== 1'b1) $display("FAIL bounds_ack0 got %b exp 1", ack0); else passed++;
    step();
    step();
    total++; if ({rvalid0, rerror, rdata[7:0]} !== {2'b10, rom[20]}) $display("FAIL bounds_ok got %b/%b/%h exp 1/0/%h", rvalid0, rerror, rdata[7:0], rom[20]); else passed++;
  endtask

  task automatic test_busy_ignore();
    do_reset();
    req0 = 1; addr0 = 7'd5; extra0 = 0; lower0 = 0; upper0 = 127;
    step();
    req0 = 0;
    total++; if (mem_addr !== 7'd5) $display("FAIL busy_addr_c1 got %0d exp 5", mem_addr); else passed++;
    step();
    req1 = 1; addr1 = 7'd50; extra1 = 0; lower1 = 0; upper1 = 127;
    total++; if ({ack1, mem_addr} !== {1'b0, 7'd5}) $display("FAIL busy_c2 got %b/%0d exp 0/5", ack1, mem_addr); else passed++;
    step();
    total++; if ({ack1, rvalid0} !== 2'b01) $display("FAIL busy_c3 got %b exp 01", {ack1, rvalid0}); else passed++;
    step();
    req1 = 0;
    total++; if ({ack1, mem_addr} !== {1'b1, 7'd50}) $display("FAIL busy_c4 got %b/%0d exp 1/50", ack1, mem_addr); else passed++;
    step();
    step();
    total++; if ({rvalid1, rdata[7:0]} !== {1'b1, rom[50]}) $display("FAIL busy_c6 got %b/%h exp 1/%h", rvalid1, rdata[7:0], rom[50]); else passed++;
  endtask

  task automatic test_latency3();
    logic [DW-1:0] exp_d;
    do_reset();
    exp_d = '0;
    exp_d[23:0] = {rom[9], rom[8], rom[7]};
    req1_3 = 1; addr1_3 = 7'd7; extra1_3 = 4'd2; lower1_3 = 0; upper1_3 = 127;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) req1_3 = 0;
      total++; if ({ack1_3, rvalid1_3, busy_3} !== {c == 1, c == 5, c >= 1 && c <= 4}) $display("FAIL lat3_c%0d got %b exp %b", c, {ack1_3, rvalid1_3, busy_3}, {c == 1, c == 5, c >= 1 && c <= 4}); else passed++;
      if (c == 5) begin
        total++; if ({rdata_3, rerror_3} !== {exp_d, 1'b0}) $display("FAIL lat3_data got %h exp %h", rdata_3, exp_d); else passed++;
      end
    end
  endtask

  task automatic test_random();
    int nf, lg, w, ack_c, ack_p, rv_c, rv_p;
    logic [DW-1:0] exp_d;
    logic exp_e;
    do_reset();
    nf = 0; lg = 1; ack_c = -1; ack_p = 0; rv_c = -1; rv_p = 0; exp_d = '0; exp_e = 0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) begin
        total++; if ({ack0, ack1} !== {ack_c == c && ack_p == 0, ack_c == c && ack_p == 1}) $display("FAIL rnd_ack_c%0d got %b exp %b", c, {ack0, ack1}, {ack_c == c && ack_p == 0, ack_c == c && ack_p == 1}); else passed++;
        total++; if ({rvalid0, rvalid1} !== {rv_c == c && rv_p == 0, rv_c == c && rv_p == 1}) $display("FAIL rnd_rvalid_c%0d got %b exp %b", c, {rvalid0, rvalid1}, {rv_c == c && rv_p == 0, rv_c == c && rv_p == 1}); else passed++;
        if (rv_c == c) begin
          total++; if ({rdata, rerror} !== {exp_d, exp_e}) $display("FAIL rnd_data_c%0d got %h/%b exp %h/%b", c, rdata, rerror, exp_d, exp_e); else passed++;
        end
      end
      // Requesters: drop and move on after ack, occasionally give up early, raise new requests
      if (ack0) begin req0 = 0; addr0 = 7'($urandom_range(0, 127)); end
      if (ack1) begin req1 = 0; addr1 = 7'($urandom_range(0, 127)); end
      if (req0 && !ack0 && $urandom_range(0, 15) == 0) req0 = 0;
      if (req1 && !ack1 && $urandom_range(0, 15) == 0) req1 = 0;
      if (!req0 && !ack0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; addr0 = 7'($urandom_range(0, 127)); extra0 = 4'($urandom_range(0, 15));
        lower0 = 7'($urandom_range(0, 40)); upper0 = 7'($urandom_range(60, 127));
      end
      if (!req1 && !ack1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; addr1 = 7'($urandom_range(0, 127)); extra1 = 4'($urandom_range(0, 15));
        lower1 = 7'($urandom_range(0, 40)); upper1 = 7'($urandom_range(60, 127));
      end
      // Reference: the port is free again on the cycle its previous answer is delivered
      if (c >= nf && (req0 || req1)) begin
        w = (req0 && req1) ? 1 - lg : (req1 ? 1 : 0);
        lg = w; ack_c = c + 1; ack_p = w; rv_c = c + LAT + 2; rv_p = w; nf = c + LAT + 2;
        exp_d = (w == 1) ? rom_read(addr1, extra1) : rom_read(addr0, extra0);
        exp_e = (w == 1) ? rom_err(addr1, extra1, lower1, upper1) : rom_err(addr0, extra0, lower0, upper0);
      end
      step();
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
    rom[33] = 8'h20;
    rom[34] = 8'h03;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_reset_mid_read();
    test_tie();
    test_bounds();
    test_busy_ignore();
    test_latency3();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
